// File: rtl/coproc_mem_responder.sv
// Memory-side responder for the arithmetic coprocessor: 16-bit word memory,
// host access port, writeback counting and run sequencing with a watchdog.
module coproc_mem_responder #(
   parameter int unsigned DEPTH        = 256,
   parameter int unsigned WB_BASE      = 14,
   parameter int unsigned RESULT_WORDS = 13,
   parameter int unsigned TIMEOUT      = 1023
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        host_we,
   input  logic        host_re,
   input  logic [7:0]  host_addr,
   input  logic [15:0] host_wdata,
   output logic [15:0] host_rdata,
   output logic        host_rvalid,
   input  logic        host_go,
   output logic        host_busy,
   input  logic [7:0]  cop_address,
   output logic [15:0] cop_rdata,
   input  logic        cop_wb,
   input  logic [15:0] cop_wdata,
   output logic        start_process,
   output logic [4:0]  wb_count,
   output logic        results_ready,
   output logic        done,
   output logic        timeout,
   output logic        collision
);

   localparam int unsigned AW  = 8;
   localparam int unsigned DW  = 16;
   localparam int unsigned CW  = 5;
   localparam int unsigned WDW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRIME,
      S_START,
      S_RUN,
      S_DONE
   } state_t;

   state_t           state;
   logic [DW-1:0]    mem [DEPTH];
   logic             prev_wb;
   logic [AW-1:0]    prev_addr;
   logic             seen_nz;
   logic [WDW-1:0]   watchdog;
   logic             host_ok;
   logic             wb_new;
   logic [CW-1:0]    wb_count_nxt;

   // Storage only, never reset; coprocessor write lands after host write.
   always_ff @(posedge clk) begin
      if (host_we && host_ok) mem[host_addr] <= host_wdata;
      if (cop_wb)             mem[cop_address] <= cop_wdata;
   end

   // A new writeback word starts on a rising cop_wb or an address change.
   always_comb begin
      host_ok      = !host_busy;
      wb_new       = cop_wb && (!prev_wb || (cop_address != prev_addr))
                     && (cop_address >= AW'(WB_BASE));
      wb_count_nxt = wb_count;
      if (wb_new && (wb_count != '1)) wb_count_nxt = wb_count + CW'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= S_IDLE;
         host_rdata    <= '0;
         host_rvalid   <= 1'b0;
         host_busy     <= 1'b0;
         cop_rdata     <= '0;
         start_process <= 1'b0;
         wb_count      <= '0;
         results_ready <= 1'b0;
         done          <= 1'b0;
         timeout       <= 1'b0;
         collision     <= 1'b0;
         prev_wb       <= 1'b0;
         prev_addr     <= '0;
         seen_nz       <= 1'b0;
         watchdog      <= '0;
      end else begin
         cop_rdata     <= mem[cop_address];
         prev_wb       <= cop_wb;
         prev_addr     <= cop_address;
         host_rvalid   <= host_re && host_ok;
         if (host_re && host_ok) host_rdata <= mem[host_addr];
         if ((host_we || host_re) && !host_ok) collision <= 1'b1;
         wb_count      <= wb_count_nxt;
         results_ready <= (wb_count_nxt >= CW'(RESULT_WORDS));
         start_process <= 1'b0;

         case (state)
            S_IDLE, S_DONE: begin
               if (host_go) begin
                  state         <= S_PRIME;
                  host_busy     <= 1'b1;
                  wb_count      <= '0;
                  results_ready <= 1'b0;
                  done          <= 1'b0;
                  timeout       <= 1'b0;
                  watchdog      <= '0;
                  seen_nz       <= 1'b0;
               end
            end
            // cop_rdata settles to mem[0] while the coprocessor idles at address 0
            S_PRIME: begin
               state         <= S_START;
               start_process <= 1'b1;
            end
            S_START: state <= S_RUN;
            S_RUN: begin
               if (cop_address != '0) seen_nz <= 1'b1;
               if (seen_nz && (cop_address == '0)) begin
                  state     <= S_DONE;
                  host_busy <= 1'b0;
                  done      <= 1'b1;
               end else if (watchdog == WDW'(TIMEOUT - 1)) begin
                  state     <= S_DONE;
                  host_busy <= 1'b0;
                  done      <= 1'b1;
                  timeout   <= 1'b1;
               end else begin
                  watchdog <= watchdog + WDW'(1);
               end
            end
            default: begin
               state     <= S_IDLE;
               host_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/coproc_mem_responder.md
Name: coproc_mem_responder

Overview:
Memory-side responder for the arithmetic coprocessor's instruction/data/writeback bus. It holds a word-addressed 16-bit memory, returns read data one cycle after address, and captures coprocessor writebacks. It also sequences runs for the host: the host loads memory, pulses go, and the block issues the one-cycle start strobe and waits for the coprocessor to return to address 0. Sits between the host/test harness and the coprocessor's Mem_data / mem_address / WB / result ports.

Parameters:
DEPTH, 256, number of 16-bit memory words (address width fixed at 8).
WB_BASE, 14, first writeback address used by the coprocessor.
RESULT_WORDS, 13, halfwords per full result (25 bytes packed two per word, last word padded).
TIMEOUT, 1023, RUN-state cycle limit before abort.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
host_we  in  1  host write strobe, honoured only when host_busy=0
host_re  in  1  host read strobe, honoured only when host_busy=0
host_addr  in  8  host word address
host_wdata  in  16  host write data
host_rdata  out  16  host read data, registered
host_rvalid  out  1  one-cycle pulse, host_rdata valid
host_go  in  1  request a coprocessor run; sampled in IDLE/DONE only
host_busy  out  1  high in PRIME, START, RUN
cop_address  in  8  coprocessor memory address
cop_rdata  out  16  data to coprocessor Mem_data, registered
cop_wb  in  1  coprocessor writeback enable (level)
cop_wdata  in  16  coprocessor writeback data
start_process  out  1  start strobe to coprocessor
wb_count  out  5  distinct writeback words captured this run
results_ready  out  1  wb_count reached RESULT_WORDS
done  out  1  run finished (normal or timeout), sticky until next go
timeout  out  1  last run aborted by watchdog
collision  out  1  sticky: host access attempted while busy

Behaviour:
- Reset: all outputs 0, FSM=IDLE, internal last-write address/valid cleared, watchdog=0. Memory contents are not cleared.
- Coprocessor read: every cycle, cop_rdata <= mem[cop_address]. Latency is 1 cycle, with no enable. If the address matches a same-cycle write, cop_rdata returns the old data.
- Coprocessor write: while cop_wb=1, mem[cop_address] <= cop_wdata every cycle. The coprocessor holds each address for 4 cycles; the last cycle's data wins.
- Distinct-word counting: wb_count increments, saturating at 31, when cop_wb=1 and (previous-cycle cop_wb=0 or cop_address differs from the previous-cycle address). Writes below WB_BASE are still stored but not counted.
- results_ready=1 when wb_count >= RESULT_WORDS. Cleared on a go.
- Host port: a host write stores to mem[host_addr]. A host read gives host_rdata=mem[host_addr] next cycle with host_rvalid=1 for 1 cycle. host_we and host_re together: write takes effect, read returns old data.
- Host access with host_busy=1: the access is ignored, no rvalid, and collision is set. collision is cleared only by reset.
- FSM states:
  - IDLE / DONE, host_busy=0: host_go=1 -> PRIME, and clears wb_count, results_ready, done, timeout and the watchdog.
  - PRIME, 1 cycle: cop_rdata settles to mem[0] (the coprocessor sits at address 0 in FETCH). -> START.
  - START, 1 cycle: start_process=1 for exactly this cycle. -> RUN.
  - RUN:
    - seen_nz sets when cop_address != 0.
    - Exit -> DONE with done=1 when seen_nz=1 and cop_address==0 (coprocessor CLEANUP). This covers both load runs (no writeback) and arithmetic runs.
    - Watchdog counts RUN cycles. Reaching TIMEOUT -> DONE with done=1, timeout=1.
- host_go in PRIME/START/RUN is ignored and does not set collision.
- A reset mid-run returns to IDLE immediately, start_process=0, and the counters are cleared.

Test Plan:
- Host writes 0x0011 to addr0, then reads addr0 -> host_rvalid pulses 1 cycle later with host_rdata=0x0011. A read of addr0 on the following cycle also returns 0x0011.
- Go from IDLE -> host_busy=1; start_process=1 on exactly the 2nd cycle after go; cop_rdata=mem[0] in that cycle.
- Emulate writeback: cop_wb=1 with addresses 14..26, each held 4 cycles, data 0x0102+i -> wb_count=13, results_ready=1, mem[14]=0x0102, mem[26]=0x010E. Then cop_address 0 -> done=1, host_busy=0.
- Load run: cop_address goes 1,2,3,0 with no cop_wb -> done=1, wb_count=0, results_ready=0.
- Host write to addr5 during RUN -> mem[5] unchanged, collision=1, and it stays 1 after done.
- Coprocessor holds cop_address=0 through RUN (never nonzero) -> after TIMEOUT cycles, done=1 and timeout=1. Asserting reset mid-run -> all outputs 0 next edge.
